alu_issue_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit CPU: fetches 24-bit instructions, decodes them and reads the 8x8 signed register file.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/seq_regfile.sv | 35 +++
 rtl/alu_issue_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: instruction layout, classes, FSM states, ALU opcodes.
package cpu_pkg;

    localparam int INSTR_W = 24;
    localparam int OP_W    = 5;

    typedef enum logic [1:0] {
        CLS_MVI  = 2'b00,
        CLS_MOV  = 2'b01,
        CLS_ALU  = 2'b10,
        CLS_HALT = 2'b11
    } cls_e;

    // Field order matches the instruction word from bit 23 down to bit 0.
    typedef struct packed {
        cls_e       cls;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [4:0] op;
        logic [2:0] rsvd;
        logic [7:0] imm;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 5'd4;

    function automatic instr_t to_instr(input logic [INSTR_W-1:0] w);
        return instr_t'(w);
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// Register file: NUM_REGS x DATA_W, two asynchronous read ports, one synchronous write port.
// Reads are combinational; a write lands on the next rising edge. No backpressure.
// Async active-low reset clears every register to zero.
module seq_regfile #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Fetch/decode/issue/write-back control for the 8-bit CPU; owns PC and register file.
// MVI/MOV take 3 cycles, ALU ops 5 plus any alu_ready and result stalls.
// Operands and opcode are held stable in ISSUE until alu_ready; WAIT has no timeout.
module alu_issue_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic               alu_res_valid,
    input  logic [DATA_W-1:0]  alu_res,
    output logic               busy,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    localparam int RF_AW = $clog2(NUM_REGS);

    state_e            state;
    state_e            state_nxt;
    instr_t            dec;
    logic              rf_we;
    logic [RF_AW-1:0]  ir_rd;
    logic [OP_W-1:0]   ir_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic              unused_rsvd;

    // The word is only meaningful in DECODE, one cycle after the FETCH strobe.
    assign dec         = to_instr(imem_rdata);
    assign unused_rsvd = ^dec.rsvd;

    seq_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .AW       (RF_AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (dec.rd),
        .rdata_a (rd_val),
        .raddr_b (dec.rs),
        .rdata_b (rs_val),
        .we      (rf_we),
        .waddr   (ir_rd),
        .wdata   (wb_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (dec.cls)
                    CLS_ALU:  state_nxt = ST_ISSUE;
                    CLS_HALT: state_nxt = ST_HALT;
                    default:  state_nxt = ST_WB;
                endcase
            end
            ST_ISSUE: begin
                if (alu_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (alu_res_valid) begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB:   state_nxt = ST_FETCH;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_en   = 1'b0;
        alu_valid = 1'b0;
        rf_we     = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        case (state)
            ST_IDLE:  busy = 1'b0;
            ST_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            ST_FETCH: imem_en   = 1'b1;
            ST_ISSUE: alu_valid = 1'b1;
            ST_WB:    rf_we     = 1'b1;
            default:  ;
        endcase
    end

    // Operands are captured in DECODE so the register file is never re-read
    // mid-instruction; with rd==rs both ports see the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            ir_rd   <= '0;
            ir_op   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc <= '0;
                    end
                end
                ST_DECODE: begin
                    ir_rd   <= dec.rd;
                    ir_op   <= dec.op;
                    op_a    <= rd_val;
                    op_b    <= rs_val;
                    wb_data <= (dec.cls == CLS_MVI) ? DATA_W'(dec.imm) : rs_val;
                end
                ST_WAIT: begin
                    if (alu_res_valid) begin
                        wb_data <= alu_res;
                    end
                end
                ST_WB: pc <= pc + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign alu_op    = ir_op;
    assign alu_a     = op_a;
    assign alu_b     = op_b;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: instruction-level reference model, responding ALU, vector table and corner sequences.
module tb_alu_issue_sequencer;
    import cpu_pkg::*;

    localparam int AW = 7;
    localparam logic [23:0] HALT_W = 24'hC00000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        imem_en;
    logic [AW-1:0] imem_addr;
    logic [23:0] imem_rdata;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [4:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_res_valid = 1'b0;
    logic [7:0]  alu_res = 8'h00;
    logic        busy, halted;
    logic [AW-1:0] pc;

    logic        start_w = 1'b0;
    logic        imem_en_w;
    logic [1:0]  imem_addr_w, pc_w;
    logic [23:0] imem_rdata_w;
    logic        alu_valid_w;
    logic        alu_ready_w = 1'b0;
    logic [4:0]  alu_op_w;
    logic [7:0]  alu_a_w, alu_b_w;
    logic        alu_res_valid_w = 1'b0;
    logic [7:0]  alu_res_w = 8'hAA;
    logic        busy_w, halted_w;

    alu_issue_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_res_valid(alu_res_valid), .alu_res(alu_res),
        .busy(busy), .halted(halted), .pc(pc)
    );

    alu_issue_sequencer #(.ADDR_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w),
        .imem_en(imem_en_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
        .alu_valid(alu_valid_w), .alu_ready(alu_ready_w), .alu_op(alu_op_w),
        .alu_a(alu_a_w), .alu_b(alu_b_w), .alu_res_valid(alu_res_valid_w), .alu_res(alu_res_w),
        .busy(busy_w), .halted(halted_w), .pc(pc_w)
    );

    logic [23:0] mem   [0:127];
    logic [23:0] mem_w [0:3];
    logic [23:0] prog  [0:127];
    logic [7:0]  mreg  [0:7];

    always @(posedge clk) if (imem_en)   imem_rdata   <= mem[imem_addr];
    always @(posedge clk) if (imem_en_w) imem_rdata_w <= mem_w[imem_addr_w];

    int total = 0;
    int bad   = 0;
    int cfg_stall = 0, cfg_rdly = 0, cfg_rand = 0;
    int cyc = 0;
    int fetch_cyc[$];
    logic [AW-1:0] fetch_addr[$];
    logic [20:0] exp_iss[$];
    logic [20:0] act_iss[$];
    logic [20:0] last_iss = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return a;
        endcase
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (imem_en) begin
                fetch_cyc.push_back(cyc);
                fetch_addr.push_back(imem_addr);
            end
        end
    end

    // Responding ALU: stalls alu_ready, delays the result, and scatters
    // garbage result strobes wherever the sequencer must ignore them.
    initial begin : alu_bfm
        int scnt, rcnt, ph;
        logic fresh;
        logic [20:0] cap;
        logic [7:0] res;
        ph = 0; scnt = 0; rcnt = 0; cap = '0; res = '0; fresh = 1'b0;
        forever begin
            @(negedge clk);
            alu_ready = 1'b0;
            alu_res_valid = 1'b0;
            alu_res = 8'($urandom);
            if (!rst_n) begin
                ph = 0;
            end else begin
                fresh = 1'b0;
                if (ph == 0 && alu_valid) begin
                    cap = {alu_op, alu_a, alu_b};
                    scnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_stall;
                    rcnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_rdly;
                    ph = 1;
                    fresh = 1'b1;
                end
                if (ph == 1) begin
                    if (!fresh) chk("operand hold", {alu_valid, alu_op, alu_a, alu_b}, {1'b1, cap});
                    if (scnt == 0) begin
                        alu_ready = 1'b1;
                        act_iss.push_back(cap);
                        res = alu_f(cap[20:16], cap[15:8], cap[7:0]);
                        ph = 2;
                    end else begin
                        scnt--;
                    end
                    if ($urandom_range(0, 3) == 0) alu_res_valid = 1'b1;
                end else if (ph == 2) begin
                    if (rcnt == 0) begin
                        alu_res_valid = 1'b1;
                        alu_res = res;
                        ph = 0;
                    end else begin
                        rcnt--;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    alu_res_valid = 1'b1;
                end
            end
        end
    end

    task automatic wait_halted(input string tag);
        int k;
        k = 0;
        while (!halted && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " halted"}, 32'(halted), 32'd1);
    endtask

    // Loads prog[0..n-1] followed by HALT, executes it in the model, runs the DUT and compares.
    task automatic run_prog(input int n, input string tag);
        int pcm, steps, nexp;
        logic [23:0] ins;
        logic [20:0] e, g;
        for (int i = 0; i < 128; i++) mem[i] = (i < n) ? prog[i] : HALT_W;
        pcm = 0; steps = 0;
        exp_iss.delete();
        act_iss.delete();
        while (mem[pcm][23:22] != 2'b11 && steps < 500) begin
            ins = mem[pcm];
            case (ins[23:22])
                2'b00: mreg[ins[21:19]] = ins[7:0];
                2'b01: mreg[ins[21:19]] = mreg[ins[18:16]];
                default: begin
                    exp_iss.push_back({ins[15:11], mreg[ins[21:19]], mreg[ins[18:16]]});
                    mreg[ins[21:19]] = alu_f(ins[15:11], mreg[ins[21:19]], mreg[ins[18:16]]);
                end
            endcase
            pcm = (pcm + 1) % 128;
            steps++;
        end
        @(negedge clk);
        fetch_cyc.delete();
        fetch_addr.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (cfg_rand != 0) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_halted(tag);
        chk({tag, " pc"}, 32'(pc), 32'(pcm));
        nexp = exp_iss.size();
        chk({tag, " issue count"}, 32'(act_iss.size()), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            e = exp_iss.pop_front();
            if (act_iss.size() > 0) begin
                g = act_iss.pop_front();
                last_iss = g;
                chk($sformatf("%s issue%0d", tag, i), 32'(g), 32'(e));
            end
        end
    endtask

    task automatic load_dump();
        for (int k = 0; k < 8; k++) prog[k] = {2'b10, 3'(k), 3'(k), 5'd31, 11'd0};
    endtask

    typedef struct {
        logic [23:0] ins;
        int          stall;
        int          rdly;
        int          cycles;
        logic        is_alu;
        logic [7:0]  a;
        logic [7:0]  b;
    } vec_t;

    initial begin : main
        vec_t tbl [9];
        int n, got_cyc, nf;
        logic [1:0] c;

        tbl[0] = '{24'h1800FB, 0, 0, 3, 1'b0, 8'h00, 8'h00};  // MVI R3,#-5
        tbl[1] = '{24'h08000A, 0, 0, 3, 1'b0, 8'h00, 8'h00};  // MVI R1,#10
        tbl[2] = '{24'h100014, 0, 0, 3, 1'b0, 8'h00, 8'h00};  // MVI R2,#20
        tbl[3] = '{24'h8A0000, 4, 0, 9, 1'b1, 8'h0A, 8'h14};  // ADD R1,R2, 4 ready stalls
        tbl[4] = '{24'h610000, 0, 0, 3, 1'b0, 8'h00, 8'h00};  // MOV R4,R1
        tbl[5] = '{24'hA40000, 0, 2, 7, 1'b1, 8'h1E, 8'h1E};  // ADD R4,R4 alias
        tbl[6] = '{24'h9C0800, 1, 1, 7, 1'b1, 8'hFB, 8'h3C};  // SUB R3,R4
        tbl[7] = '{24'h430000, 0, 0, 3, 1'b0, 8'h00, 8'h00};  // MOV R0,R3
        tbl[8] = '{24'h812000, 0, 0, 5, 1'b1, 8'hBF, 8'h1E};  // XOR R0,R1

        for (int k = 0; k < 8; k++) mreg[k] = 8'h00;
        mem_w[0] = 24'h080001; mem_w[1] = 24'h100002;
        mem_w[2] = 24'h180003; mem_w[3] = 24'h200004;

        repeat (3) @(negedge clk);
        chk("reset outputs", {imem_en, alu_valid, busy, halted, pc, imem_addr, alu_op, alu_a, alu_b},
            32'd0);
        rst_n = 1'b1;

        // Reset while the ALU request is stalled.
        for (int i = 0; i < 128; i++) mem[i] = HALT_W;
        mem[0] = 24'h280007;
        mem[1] = 24'hAD0000;
        cfg_stall = 10;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!alu_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue reached", 32'(alu_valid), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("mid-issue reset", {alu_valid, busy, halted, imem_en, 7'(pc)}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cfg_stall = 0;
        for (int k = 0; k < 8; k++) mreg[k] = 8'h00;
        load_dump();
        run_prog(8, "dump_reset");

        for (int v = 0; v < 9; v++) begin
            cfg_stall = tbl[v].stall;
            cfg_rdly  = tbl[v].rdly;
            prog[0]   = tbl[v].ins;
            run_prog(1, $sformatf("vec%0d", v));
            got_cyc = (fetch_cyc.size() >= 2) ? fetch_cyc[1] - fetch_cyc[0] : 0;
            chk($sformatf("vec%0d cycles", v), 32'(got_cyc), 32'(tbl[v].cycles));
            if (tbl[v].is_alu)
                chk($sformatf("vec%0d operands", v), 32'(last_iss),
                    32'({tbl[v].ins[15:11], tbl[v].a, tbl[v].b}));
        end
        cfg_stall = 0; cfg_rdly = 0;
        load_dump();
        run_prog(8, "dump_tbl");

        // HALT at address 5, PC hold, restart from 0 with registers kept.
        prog[0] = 24'h280055; prog[1] = 24'h300080; prog[2] = 24'h38007F;
        prog[3] = 24'h570000; prog[4] = 24'h960000;
        run_prog(5, "halt5");
        chk("halt flags", {halted, busy}, 2'b10);
        repeat (6) @(negedge clk);
        chk("halt pc held", 32'(pc), 32'd5);
        load_dump();
        run_prog(8, "dump_halt");
        chk("restart addr", (fetch_addr.size() > 0) ? 32'(fetch_addr[0]) : 32'hFFFF, 32'd0);

        // PC wrap on a 2-bit address space, stray result strobes during FETCH.
        @(negedge clk); start_w = 1'b1;
        @(negedge clk); start_w = 1'b0;
        nf = 0; n = 0;
        while (nf < 5 && n < 40) begin
            alu_res_valid_w = imem_en_w;
            if (imem_en_w) begin
                chk($sformatf("wrap addr%0d", nf), 32'(imem_addr_w), 32'(nf % 4));
                chk($sformatf("wrap pc%0d", nf), 32'(pc_w), 32'(nf % 4));
                chk($sformatf("wrap status%0d", nf),
                    {alu_valid_w, halted_w, busy_w, alu_op_w, alu_a_w, alu_b_w}, {3'b001, 21'd0});
                nf++;
            end
            @(negedge clk);
            n++;
        end
        alu_res_valid_w = 1'b0;
        chk("wrap fetches", 32'(nf), 32'd5);

        cfg_rand = 1;
        for (int p = 0; p < 8; p++) begin
            n = int'($urandom_range(4, 16));
            for (int i = 0; i < n; i++) begin
                c = 2'($urandom_range(0, 2));
                prog[i] = {c, 3'($urandom), 3'($urandom), 5'($urandom_range(0, 4)), 3'($urandom), 8'($urandom)};
            end
            run_prog(n, $sformatf("rnd%0d", p));
        end
        load_dump();
        run_prog(8, "dump_rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
